// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   arb_state_t : sequencing FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   arb_owner_t : which requester currently owns the memory port
//   WORD_MASK   : clears the byte-offset bits of a byte address
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DMA = 1'b1
    } arb_owner_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/arb_latency_timer.sv
// -----------------------------------------------------------------------------
// arb_latency_timer
//   Loadable down-counter that times the memory latency window.
//   Ports:
//     clk, reset_n : clock, async active-low reset
//     load         : load MEM_LAT-1 (asserted in the cycle before WAIT)
//     run          : count down while in WAIT
//     expire       : count has reached 0 (last WAIT cycle)
// -----------------------------------------------------------------------------
module arb_latency_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= 4'd0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (run && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign expire = (cnt == 4'd0);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU MEM stage and a DMA /
//   debug loader. CPU has priority; a starvation counter forces a DMA grant
//   after STARVE_MAX consecutive CPU grants while DMA waits. Each access runs
//   IDLE -> ISSUE -> WAIT(MEM_LAT cycles) -> DONE.
//   Ports:
//     clk, reset_n                          : clock, async active-low reset
//     cpu_req/we/addr/wdata, cpu_rdata      : CPU request and read data
//     cpu_stall                             : combinational pipeline stall
//     dma_req/we/addr/wdata, dma_rdata      : DMA request and read data
//     dma_ack                               : one-cycle completion pulse
//     mem_en/we/addr/wdata, mem_rdata       : memory port
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state, state_nxt;
    arb_owner_t owner;
    logic       own_we;
    logic [3:0] starve_cnt;
    logic       grant;
    logic       grant_dma;
    logic       expire;

    // Selected request fields at the grant edge
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign sel_we    = grant_dma ? dma_we    : cpu_we;
    assign sel_addr  = grant_dma ? dma_addr  : cpu_addr;
    assign sel_wdata = grant_dma ? dma_wdata : cpu_wdata;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // FSM: next state and grant decision (grants only happen in IDLE)
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_dma = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant     = 1'b1;
                    // DMA wins a tie only once the CPU has had its run
                    grant_dma = dma_req && (!cpu_req || starve_cnt == STARVE_LIM);
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Latency timer: loaded in ISSUE so WAIT lasts exactly MEM_LAT cycles
    // -------------------------------------------------------------------------
    arb_latency_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == ISSUE),
        .run     (state == WAIT),
        .expire  (expire)
    );

    // -------------------------------------------------------------------------
    // Grant-edge capture: owner, request fields, memory strobe, starve count.
    // mem_addr / mem_wdata double as the latched request fields.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= CPU;
            own_we     <= 1'b0;
            starve_cnt <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            // strobe is high only in ISSUE
            mem_en <= grant;
            mem_we <= grant && sel_we;
            if (grant) begin
                owner     <= grant_dma ? DMA : CPU;
                own_we    <= sel_we;
                mem_addr  <= sel_addr & WORD_MASK;
                mem_wdata <= sel_wdata;
                if (!grant_dma && dma_req)
                    starve_cnt <= starve_cnt + 4'd1;
                else
                    starve_cnt <= 4'd0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read data capture at the last WAIT edge; writes leave rdata untouched
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata <= 32'd0;
            dma_rdata <= 32'd0;
        end else if (state == WAIT && expire && !own_we) begin
            if (owner == CPU)
                cpu_rdata <= mem_rdata;
            else
                dma_rdata <= mem_rdata;
        end
    end

    assign cpu_stall = cpu_req && !(state == DONE && owner == CPU);
    assign dma_ack   = (state == DONE) && (owner == DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiter instances: dut_a (MEM_LAT=1) and dut_b (MEM_LAT=3), each with
//   its own behavioural memory that only presents read data in the cycle the
//   latency contract promises (garbage otherwise).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    // ---------------- dut_a signals ----------------
    logic        a_cpu_req, a_cpu_we, a_cpu_stall;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic        a_dma_req, a_dma_we, a_dma_ack;
    logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // ---------------- dut_b signals ----------------
    logic        b_cpu_req, b_cpu_we, b_cpu_stall;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic        b_dma_req, b_dma_we, b_dma_ack;
    logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    dmem_arbiter #(.MEM_LAT(LAT_A), .STARVE_MAX(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr),
        .dma_wdata(a_dma_wdata), .dma_rdata(a_dma_rdata), .dma_ack(a_dma_ack),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(LAT_B), .STARVE_MAX(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr),
        .dma_wdata(b_dma_wdata), .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem_a [0:255];
    logic [31:0] a_rd_addr = 32'd0;
    logic [7:0]  a_age = 8'd0;

    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
            a_rd_addr <= a_mem_addr;
            a_age     <= 8'd1;
        end else if (a_age != 8'd0 && a_age != 8'hFF) begin
            a_age <= a_age + 8'd1;
        end
    end
    assign a_mem_rdata = (a_age == 8'(LAT_A)) ? mem_a[a_rd_addr[9:2]] : 32'hBAD0_BAD0;

    logic [31:0] mem_b [0:255];
    logic [31:0] b_rd_addr = 32'd0;
    logic [7:0]  b_age = 8'd0;

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
            b_rd_addr <= b_mem_addr;
            b_age     <= 8'd1;
        end else if (b_age != 8'd0 && b_age != 8'hFF) begin
            b_age <= b_age + 8'd1;
        end
    end
    assign b_mem_rdata = (b_age == 8'(LAT_B)) ? mem_b[b_rd_addr[9:2]] : 32'hBAD0_BAD0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;  // owner's rdata at DONE (held value for writes)
    } vec_t;

    vec_t vecs [8];
    logic exp_seq [10];
    logic got_seq [10];

    initial begin
        // {is_dma, we, addr, wdata, exp_addr, exp_rdata}
        vecs[0] = '{1'b1, 1'b1, 32'h40, 32'd4862,      32'h40, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h41, 32'h0,         32'h40, 32'd4862};
        vecs[2] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF,  32'h10, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h10, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h23, 32'h12345678,  32'h20, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h22, 32'h0,         32'h20, 32'h12345678};
        vecs[6] = '{1'b1, 1'b1, 32'h13, 32'hCAFEF00D,  32'h10, 32'h12345678};
        vecs[7] = '{1'b0, 1'b0, 32'h12, 32'h0,         32'h10, 32'hCAFEF00D};
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h0; a_cpu_wdata = 32'h0;
        a_dma_req = 1'b0; a_dma_we = 1'b0; a_dma_addr = 32'h0; a_dma_wdata = 32'h0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 32'h0; b_cpu_wdata = 32'h0;
        b_dma_req = 1'b0; b_dma_we = 1'b0; b_dma_addr = 32'h0; b_dma_wdata = 32'h0;

        // ---------------- reset state ----------------
        #2;
        check("rst_stall_follows_req1", a_cpu_stall, 1);
        check("rst_mem_en", a_mem_en, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_dma_ack", a_dma_ack, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_cpu_rdata", a_cpu_rdata, 0);
        check("rst_dma_rdata", a_dma_rdata, 0);
        check("rst_b_dma_ack", b_dma_ack, 0);
        check("rst_b_dma_rdata", b_dma_rdata, 0);
        a_cpu_req = 1'b0;
        #1;
        check("rst_stall_follows_req0", a_cpu_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ---------------- table-driven single accesses (MEM_LAT=1) ----------------
        for (int i = 0; i < 8; i++) begin
            // cycle 0
            if (vecs[i].is_dma) begin
                a_dma_req = 1'b1; a_dma_we = vecs[i].we;
                a_dma_addr = vecs[i].addr; a_dma_wdata = vecs[i].wdata;
            end else begin
                a_cpu_req = 1'b1; a_cpu_we = vecs[i].we;
                a_cpu_addr = vecs[i].addr; a_cpu_wdata = vecs[i].wdata;
            end
            step();  // cycle 1: ISSUE
            check($sformatf("v%0d_c1_mem_en", i), a_mem_en, 1);
            check($sformatf("v%0d_c1_mem_addr", i), a_mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_c1_mem_we", i), a_mem_we, 32'(vecs[i].we));
            check($sformatf("v%0d_c1_mem_wdata", i), a_mem_wdata, vecs[i].wdata);
            // inputs changing after the grant must not affect the access
            if (vecs[i].is_dma) begin
                a_dma_we = ~vecs[i].we; a_dma_addr = vecs[i].addr ^ 32'hF00;
            end else begin
                a_cpu_we = ~vecs[i].we; a_cpu_addr = vecs[i].addr ^ 32'hF00;
            end
            step();  // cycle 2: WAIT
            check($sformatf("v%0d_c2_mem_en", i), a_mem_en, 0);
            check($sformatf("v%0d_c2_dma_ack", i), a_dma_ack, 0);
            if (!vecs[i].is_dma) check($sformatf("v%0d_c2_stall", i), a_cpu_stall, 1);
            step();  // cycle 3: DONE
            if (vecs[i].is_dma) begin
                check($sformatf("v%0d_c3_dma_ack", i), a_dma_ack, 1);
                check($sformatf("v%0d_c3_dma_rdata", i), a_dma_rdata, vecs[i].exp_rdata);
                a_dma_req = 1'b0;
            end else begin
                check($sformatf("v%0d_c3_stall", i), a_cpu_stall, 0);
                check($sformatf("v%0d_c3_cpu_rdata", i), a_cpu_rdata, vecs[i].exp_rdata);
                a_cpu_req = 1'b0;
            end
            step();  // cycle 4: IDLE, nothing pending
            check($sformatf("v%0d_c4_dma_ack", i), a_dma_ack, 0);
            check($sformatf("v%0d_c4_mem_en", i), a_mem_en, 0);
        end

        // ---------------- starvation: both held continuously ----------------
        begin
            int n = 0;
            a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h40;
            a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 32'h10;
            for (int c = 0; c < 200 && n < 10; c++) begin
                step();
                if (a_dma_ack) begin
                    got_seq[n] = 1'b1;
                    n++;
                    check("starve_cnt_cleared", 32'(dut_a.starve_cnt), 0);
                    check("starve_dma_rdata", a_dma_rdata, 32'hCAFEF00D);
                end else if (!a_cpu_stall) begin
                    got_seq[n] = 1'b0;
                    n++;
                end
            end
            a_cpu_req = 1'b0; a_dma_req = 1'b0;
            check("starve_completions", 32'(n), 10);
            for (int k = 0; k < 10; k++)
                if (k < n) check($sformatf("starve_order_%0d", k), 32'(got_seq[k]), 32'(exp_seq[k]));
            step(); step();
        end

        // ---------------- CPU request held across DONE ----------------
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h41;
        step(); step(); step();  // cycle 3: DONE
        check("held_c3_stall", a_cpu_stall, 0);
        check("held_c3_rdata", a_cpu_rdata, 32'd4862);
        step();                  // cycle 4: IDLE, re-granted
        check("held_c4_stall", a_cpu_stall, 1);
        check("held_c4_mem_en", a_mem_en, 0);
        step();                  // cycle 5: ISSUE of the new access
        check("held_c5_mem_en", a_mem_en, 1);
        check("held_c5_mem_addr", a_mem_addr, 32'h40);
        a_cpu_req = 1'b0;
        step(); step(); step();

        // ---------------- MEM_LAT=3 read on dut_b ----------------
        begin
            int c = 0;
            b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 32'h30; b_cpu_wdata = 32'hA5A50001;
            step();
            while (b_cpu_stall && c < 30) begin
                step();
                c++;
            end
            check("b_write_done_in_time", 32'(c < 30), 1);
            b_cpu_req = 1'b0;
            step();
        end
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h32;
        step();  // cycle 1
        check("b_c1_mem_en", b_mem_en, 1);
        check("b_c1_mem_addr", b_mem_addr, 32'h30);
        step(); step();
        step();  // cycle 4: last WAIT
        check("b_c4_stall", b_cpu_stall, 1);
        step();  // cycle 5: DONE
        check("b_c5_stall", b_cpu_stall, 0);
        check("b_c5_rdata", b_cpu_rdata, 32'hA5A50001);
        b_cpu_req = 1'b0;
        step();

        // ---------------- reset during WAIT of a DMA read ----------------
        a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 32'h40;
        step();  // cycle 1
        step();  // cycle 2: WAIT
        #2;
        reset_n = 1'b0;
        a_dma_req = 1'b0;
        #1;
        check("rstw_mem_en", a_mem_en, 0);
        check("rstw_dma_ack", a_dma_ack, 0);
        check("rstw_state", 32'(dut_a.state), 32'(IDLE));
        check("rstw_dma_rdata", a_dma_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int acks = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (a_dma_ack) acks++;
            end
            check("rstw_no_ack_after_release", 32'(acks), 0);
        end
        a_dma_req = 1'b1;
        step(); step(); step();  // cycle 3: DONE
        check("rstw_reissue_ack", a_dma_ack, 1);
        check("rstw_reissue_rdata", a_dma_rdata, 32'd4862);
        a_dma_req = 1'b0;
        step();
        check("rstw_ack_one_cycle", a_dma_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory in the pipelined MIPS system. The pipeline's MEM stage and a DMA/debug loader share one memory port. The CPU normally wins, and a bounded starvation counter guarantees DMA progress. Each access runs through a fixed-latency sequencing FSM; the CPU sees a stall and the DMA port sees a one-cycle ack.

## Interface
Parameters:
- `MEM_LAT`, 1: cycles from the memory sampling `mem_en` to `mem_rdata` being valid; legal range 1..15.
- `STARVE_MAX`, 4: maximum consecutive CPU grants while `dma_req` is pending; legal range 1..15.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `cpu_req`  in  1  — CPU access request; level, held until serviced.
- `cpu_we`  in  1  — CPU write enable.
- `cpu_addr`  in  32  — CPU byte address.
- `cpu_wdata`  in  32  — CPU write data.
- `cpu_rdata`  out  32  — CPU read data, valid while the CPU done cycle is active.
- `cpu_stall`  out  1  — stall to the pipeline; combinational.
- `dma_req`  in  1  — DMA access request; level.
- `dma_we`  in  1  — DMA write enable.
- `dma_addr`  in  32  — DMA byte address.
- `dma_wdata`  in  32  — DMA write data.
- `dma_rdata`  out  32  — DMA read data, valid with `dma_ack`.
- `dma_ack`  out  1  — one-cycle completion pulse to DMA.
- `mem_en`  out  1  — memory access strobe; registered, one cycle.
- `mem_we`  out  1  — memory write enable; registered.
- `mem_addr`  out  32  — word-aligned address; bits [1:0] forced to 0.
- `mem_wdata`  out  32  — memory write data; registered.
- `mem_rdata`  in  32  — memory read data.

## Operation
- FSM states and transitions:
  - IDLE: on a grant, go to ISSUE.
  - ISSUE: drive `mem_en` for one cycle, then go to WAIT.
  - WAIT: count `MEM_LAT` cycles, then go to DONE.
  - DONE: complete the access for one cycle, then return to IDLE.
- Grant decision, made only in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant DMA if `starve_cnt == STARVE_MAX`, otherwise grant CPU.
- The owner and its request fields (we, addr, wdata) are latched at the grant edge. Input changes after the grant are ignored until DONE.
- `starve_cnt` (4 bits) update at each grant:
  - CPU granted while `dma_req` = 1: `starve_cnt` += 1.
  - DMA granted, or CPU granted while `dma_req` = 0: `starve_cnt` cleared to 0.
- Read data: the `mem_rdata` sample is latched into the owner's rdata register at the last WAIT edge. The register holds its value until the next read by the same owner. Writes do not update it.
- `cpu_stall = cpu_req & ~(state==DONE & owner==CPU)`.
- `dma_ack = (state==DONE & owner==DMA)`; registered-state decode.
- A request still high in the IDLE cycle after DONE is treated as a new access. The pipeline must advance on the unstall cycle.
- Reset values:
  - `mem_en`, `mem_we`, `dma_ack` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0.
  - State IDLE, `starve_cnt` = 0.
  - `cpu_stall` follows `cpu_req`.
- Reset mid-access aborts the access: no ack, no unstall, and `mem_en` drops immediately (asynchronous).

## Timing
- Request first sampled high in IDLE at cycle 0:
  - `mem_en` high in cycle 1.
  - WAIT in cycles 2..1+`MEM_LAT`.
  - DONE in cycle 2+`MEM_LAT`.
- Service latency is `MEM_LAT`+2 cycles from request to DONE; reads and writes are identical.
- Peak throughput: one access per `MEM_LAT`+3 cycles.
- Memory contract: the memory samples `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` at the end of cycle 1. For a read, `mem_rdata` is valid in cycle 1+`MEM_LAT`.
- Both requests arriving in the same cycle: resolved in that IDLE cycle by the priority rule; the loser waits with its request held.
- A request arriving during ISSUE, WAIT or DONE is not considered until the next IDLE cycle.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - `arb_state_t` (IDLE, ISSUE, WAIT, DONE).
  - `arb_owner_t` (CPU, DMA).
  - Constant `WORD_MASK` = 32'hFFFF_FFFC.
- One sub-module, `arb_latency_timer`: a loadable down-counter that loads `MEM_LAT`-1 on entry to WAIT and asserts `expire` at 0.
- Everything else lives in `dmem_arbiter`.

## Test plan
- CPU read only, `MEM_LAT`=1, memory word 0x40 = 4862, `cpu_req` with addr 0x41:
  - `mem_addr` = 0x40 and `mem_en` in cycle 1.
  - `cpu_stall` low in cycle 3 with `cpu_rdata` = 4862.
- DMA write only, addr 0x10, data 0xDEADBEEF:
  - `mem_we` = 1 in cycle 1.
  - `dma_ack` pulse in cycle 3; a later CPU read of 0x10 returns 0xDEADBEEF.
- Both held continuously, `STARVE_MAX`=4: grant order CPU, CPU, CPU, CPU, DMA, CPU…, with `starve_cnt` cleared to 0 after the DMA grant.
- `MEM_LAT`=3, single CPU read: `mem_en` in cycle 1, DONE and unstall in cycle 5; `cpu_rdata` equals the memory data from cycle 4.
- `reset_n` pulled low during WAIT of a DMA read:
  - `mem_en`/`dma_ack` = 0 and state returns to IDLE.
  - No ack after release; a re-issued request completes normally.
- `cpu_req` held across DONE: new access starts in the next IDLE cycle, and `cpu_stall` rises again in that cycle.
